// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor, subtract mode under SERIAL_ADDSUB_SUB_EN
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] b_load;
    logic             carry_init;
    logic             s_bit;
    logic             carry_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_ADDSUB_SUB_EN
    // a - b is computed as a + ~b + 1: invert B and seed the carry with 1
    assign b_load     = sub ? ~b : b;
    assign carry_init = sub;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign b_load     = b;
    assign carry_init = 1'b0;
`endif

    always_comb begin
        s_bit      = a_sr[0] ^ b_sr[0] ^ carry;
        carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        res_next   = {s_bit, res_sr[WIDTH-1:1]};
        last_bit   = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b_load;
                        carry <= carry_init;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= carry_next;
                    res_sr <= res_next;
                    if (last_bit) begin
                        // MSB cycle: operands' sign bits are at position 0 right now
                        state    <= S_DONE;
                        sum      <= res_next;
                        c_out    <= carry_next;
                        overflow <= (a_sr[0] == b_sr[0]) && (s_bit != a_sr[0]);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);
endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - randomized self-checking bench for serial_addsub (8 and 16 bit)
module tb_serial_addsub;
    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       busy8, done8, c8, ovf8;

    logic        start16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        busy16, done16, c16, ovf16;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(c8), .overflow(ovf8)
    );

    serial_addsub #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .c_out(c16), .overflow(ovf16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic; returns {overflow, c_out, sum[15:0]}
    function automatic logic [17:0] model(input int w, input longint a, input longint b, input bit s);
        longint mask, full, sa, sb, r, lim;
        bit eff_sub, c, ovf;
`ifdef SERIAL_ADDSUB_SUB_EN
        eff_sub = s;
`else
        eff_sub = 1'b0;
`endif
        mask = (64'sd1 << w) - 1;
        lim  = 64'sd1 << (w - 1);
        if (eff_sub) begin
            full = (a - b) & mask;
            c    = (a >= b);
        end else begin
            full = (a + b) & mask;
            c    = ((a + b) > mask);
        end
        sa  = (a >= lim) ? a - (mask + 1) : a;
        sb  = (b >= lim) ? b - (mask + 1) : b;
        r   = eff_sub ? sa - sb : sa + sb;
        ovf = (r >= lim) || (r < -lim);
        return {ovf, c, full[15:0]};
    endfunction

    // Call at a negedge: presents the operation for the next edge
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic s);
        a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    endtask

    // Waits through one operation; returns at the negedge on which done is seen
    task automatic wait8(input bit inject, input logic [17:0] exp, input string tag);
        int edges = 0;
        int busy_n = 0;
        logic [7:0] held;
        held = sum8;
        @(posedge clk);
        #1 start8 = 1'b0;
        @(negedge clk);
        while (!done8 && edges < 40) begin
            if (busy8) busy_n++;
            chk({tag, "_hold"}, {24'd0, sum8}, {24'd0, held});
            if (inject) begin
                start8 = 1'($urandom_range(1, 0));
                a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom_range(1, 0));
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start8 = 1'b0;
        chk({tag, "_edges"}, edges, 8);
        chk({tag, "_busy"}, busy_n, 8);
        chk({tag, "_sum"}, {24'd0, sum8}, {16'd0, exp[15:0]});
        chk({tag, "_cout"}, {31'd0, c8}, {31'd0, exp[16]});
        chk({tag, "_ovf"}, {31'd0, ovf8}, {31'd0, exp[17]});
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit inject, input string tag);
        logic [17:0] e;
        e = model(8, a, b, s);
        launch8(a, b, s);
        wait8(inject, e, tag);
        @(negedge clk);
        chk({tag, "_done_drop"}, {31'd0, done8}, 0);
        chk({tag, "_idle"}, {31'd0, busy8}, 0);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s, input string tag);
        int edges = 0;
        logic [17:0] e;
        e = model(16, a, b, s);
        a16 = a; b16 = b; sub16 = s; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        @(negedge clk);
        while (!done16 && edges < 60) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk({tag, "_edges"}, edges, 16);
        chk({tag, "_sum"}, {16'd0, sum16}, {16'd0, e[15:0]});
        chk({tag, "_cout"}, {31'd0, c16}, {31'd0, e[16]});
        chk({tag, "_ovf"}, {31'd0, ovf16}, {31'd0, e[17]});
        @(negedge clk);
        chk({tag, "_done_drop"}, {31'd0, done16}, 0);
    endtask

    initial begin
        logic [17:0] e1, e2;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy8}, 0);
        chk("rst_done", {31'd0, done8}, 0);
        chk("rst_sum", {24'd0, sum8}, 0);
        chk("rst_cout", {31'd0, c8}, 0);
        chk("rst_ovf", {31'd0, ovf8}, 0);
        chk("rst_sum16", {16'd0, sum16}, 0);

        op8(8'd25, 8'd17, 1'b0, 1'b0, "add25_17");
        chk("add25_17_const", {24'd0, sum8}, 42);
        op8(8'd200, 8'd100, 1'b0, 1'b0, "add200_100");
        op8(8'd100, 8'd100, 1'b0, 1'b0, "add100_100");
        chk("add100_100_ovf_const", {31'd0, ovf8}, 1);
        op8(8'd50, 8'd20, 1'b1, 1'b0, "sub50_20");
        op8(8'd20, 8'd50, 1'b1, 1'b0, "sub20_50");
`ifdef SERIAL_ADDSUB_SUB_EN
        chk("sub20_50_const", {24'd0, sum8}, 226);
`else
        chk("sub20_50_const", {24'd0, sum8}, 70);
`endif

        // reset sampled at the 4th edge of SHIFT
        launch8(8'd25, 8'd17, 1'b0);
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, busy8}, 0);
        chk("mid_rst_done", {31'd0, done8}, 0);
        chk("mid_rst_sum", {24'd0, sum8}, 0);
        chk("mid_rst_cout", {31'd0, c8}, 0);
        chk("mid_rst_ovf", {31'd0, ovf8}, 0);
        for (int i = 0; i < 10; i++) begin
            chk("mid_rst_no_done", {31'd0, done8}, 0);
            @(negedge clk);
        end
        op8(8'd3, 8'd4, 1'b0, 1'b0, "after_rst");

        // back-to-back with start held in DONE, junk start pulses during SHIFT
        e1 = model(8, 1, 1, 0);
        e2 = model(8, 5, 9, 0);
        launch8(8'd1, 8'd1, 1'b0);
        wait8(1'b1, e1, "b2b_first");
        launch8(8'd5, 8'd9, 1'b0);
        wait8(1'b1, e2, "b2b_second");
        chk("b2b_second_const", {24'd0, sum8}, 14);
        @(negedge clk);
        chk("b2b_done_drop", {31'd0, done8}, 0);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra, rb;
            logic rs;
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(1, 0));
            op8(ra, rb, rs, 1'($urandom_range(1, 0)), $sformatf("rnd%0d", i));
        end

        op16(16'd65535, 16'd1, 1'b0, "w16_wrap");
        op16(16'h7fff, 16'h0001, 1'b0, "w16_ovf");
        for (int i = 0; i < 6; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)), $sformatf("w16_rnd%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor with integrated operand shift registers, carry flip-flop, bit counter and a start/done handshake. It generalises the 8-bit serial add datapath to any `WIDTH`, adds a subtract mode and signed-overflow detection, and captures the result in a parallel output register. It is used wherever a narrow, area-cheap arithmetic unit is acceptable at a latency of `WIDTH` cycles.

## Interface
- `WIDTH`, 8: operand and result width in bits; legal range 2 or more.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE or DONE.
- `sub` input 1: 0 = add, 1 = subtract (a − b); sampled with `start`.
- `a` input WIDTH: operand A, sampled with `start`.
- `b` input WIDTH: operand B, sampled with `start`.
- `busy` output 1: high while in SHIFT.
- `done` output 1: single-cycle completion pulse.
- `sum` output WIDTH: result register.
- `c_out` output 1: final carry-out; in subtract mode, 1 = no borrow (a ≥ b unsigned).
- `overflow` output 1: two's-complement signed overflow of the operation.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE/DONE + `start`=1:
  - load A shift register with `a`.
  - load B shift register with `b`, or with `~b` when `sub`=1.
  - set carry flip-flop to `sub`.
  - clear the bit counter.
  - go to SHIFT.
- IDLE + `start`=0: stay in IDLE.
- DONE + `start`=0: go to IDLE.
- SHIFT, each cycle:
  - s = A[0]^B[0]^carry.
  - carry ← majority(A[0], B[0], carry).
  - s shifts into the MSB of the internal result shift register (right shift).
  - A and B shift right.
  - counter increments.
- SHIFT exit: on the cycle where counter = WIDTH−1, go to DONE and in the same edge load the output registers:
  - `sum` ← completed result.
  - `c_out` ← final carry.
  - `overflow` ← (A[0] == B[0]) && (s != A[0]), using the MSB bits being processed on that cycle.
- `sum`, `c_out` and `overflow` change only on entry to DONE. They hold the previous result throughout SHIFT and until the next completion.
- `start` during SHIFT is ignored, and the operation is not restarted.
- Bit counter width is $clog2(WIDTH). The counter does not wrap within an operation.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `sum`=0, `c_out`=0, `overflow`=0. Internal shift registers, carry and counter are cleared.
- Latency: with `start` sampled at edge 0, bits are processed at edges 1..WIDTH.
- `done`=1 and the new `sum` are visible after edge WIDTH, for exactly one cycle.
- `busy`=1 after edges 0..WIDTH−1, i.e. WIDTH cycles.
- Back-to-back operation: `start`=1 while `done`=1 loads the next operation at that edge, so throughput is one result per WIDTH+1 cycles.
- `reset` during SHIFT: next state IDLE, all outputs 0, no `done` pulse. Reset has priority over `start` in the same cycle.

## Configuration
- `SERIAL_ADDSUB_SUB_EN` defined:
  - subtract mode is built as described.
- `SERIAL_ADDSUB_SUB_EN` undefined:
  - the `sub` port remains present but is ignored.
  - B always loads `b` and the carry always initialises to 0.
  - the inversion mux is removed, and the block is add-only.
- `overflow` is computed identically in both builds.

## Test plan
- WIDTH=8, add 25+17 → `sum`=42, `c_out`=0, `overflow`=0. `done` is high exactly during the cycle after edge 8, and `busy` is high for 8 cycles.
- WIDTH=8, add 200+100 → `sum`=44, `c_out`=1. Add 100+100 → `sum`=200, `overflow`=1.
- WIDTH=8 with `SERIAL_ADDSUB_SUB_EN`:
  - 50−20 → `sum`=30, `c_out`=1, `overflow`=0.
  - 20−50 → `sum`=226, `c_out`=0.
  - Without the macro, the same stimulus with `sub`=1 gives 70.
- Reset mid-operation: assert `reset` at edge 4 of a SHIFT sequence → IDLE next cycle, all outputs 0, no `done`. A subsequent 3+4 completes with `sum`=7.
- Back-to-back: 1+1 then, with `start` held high in DONE, 5+9 → `done` pulses 9 edges apart, `sum` reads 2 then 14. `start` pulses during SHIFT are ignored.
- WIDTH=16: 65535+1 → `sum`=0, `c_out`=1, `overflow`=0, with `done` after edge 16.
